// File: rtl/mdu_pkg.sv
// Shared encodings and default sizes for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_MULLO = 2'b00,
    OP_MULHI = 2'b01,
    OP_DIVQ  = 2'b10,
    OP_DIVR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One step per cycle for WIDTH cycles, then a single DONE cycle that
// strobes the register-file write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold the last result
// ST_RUN  | one shift-add / shift-subtract step per cycle
// ST_DONE | result valid, write strobe high for this single cycle
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      operandA,
  input  logic [WIDTH-1:0]      operandB,
  input  logic [ADDR_WIDTH-1:0] destAddr,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  writeEnabled,
  output logic [ADDR_WIDTH-1:0] writeAddr,
  output logic                  divByZero
);

  localparam int CW = $clog2(WIDTH);

  state_e                state, state_nxt;
  logic [CW-1:0]         cnt;
  logic [2*WIDTH-1:0]    acc;        // MUL: product; DIV: remainder in upper half
  logic [WIDTH-1:0]      shreg;      // MUL: multiplier; DIV: dividend -> quotient
  logic [WIDTH-1:0]      opa;        // multiplicand
  logic [WIDTH-1:0]      opb;        // divisor
  op_e                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  dbz_q;

  logic                  is_div;
  logic [WIDTH:0]        rem_sh;
  logic [WIDTH+1:0]      add_x, add_y, add_sum;
  logic                  add_cin;
  logic                  div_ge;
  logic [2*WIDTH:0]      mul_tmp;
  logic [WIDTH-1:0]      rem_nxt;
  logic [2*WIDTH-1:0]    acc_nxt;
  logic [WIDTH-1:0]      shreg_nxt;

  assign is_div = op_q[1];

  // Shared adder: adds the multiplicand for MUL, subtracts the divisor
  // (two's complement) from the shifted partial remainder for DIV.
  always_comb begin
    rem_sh  = {acc[2*WIDTH-1:WIDTH], shreg[WIDTH-1]};
    add_x   = {2'b00, acc[2*WIDTH-1:WIDTH]};
    add_y   = {2'b00, opa};
    add_cin = 1'b0;
    if (is_div) begin
      add_x   = {1'b0, rem_sh};
      add_y   = ~{2'b00, opb};
      add_cin = 1'b1;
    end
    add_sum = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
    // No borrow out of the 18-bit difference means remainder >= divisor.
    div_ge  = ~add_sum[WIDTH+1];
  end

  // Next accumulator / shift register value for one iteration step.
  always_comb begin
    mul_tmp   = shreg[0] ? {add_sum[WIDTH:0], acc[WIDTH-1:0]} : {1'b0, acc};
    rem_nxt   = div_ge ? add_sum[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    acc_nxt   = mul_tmp[2*WIDTH:1];
    shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
    if (is_div) begin
      acc_nxt   = {rem_nxt, acc[WIDTH-1:0]};
      shreg_nxt = {shreg[WIDTH-2:0], div_ge};
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (cnt == CW'(WIDTH-1)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, operand latches and iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      shreg  <= '0;
      opa    <= '0;
      opb    <= '0;
      op_q   <= OP_MULLO;
      addr_q <= '0;
      dbz_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc    <= '0;
            opa    <= operandA;
            opb    <= operandB;
            op_q   <= op_e'(op);
            addr_q <= destAddr;
            dbz_q  <= op[1] && (operandB == '0);
            shreg  <= op[1] ? operandA : operandB;
          end
        end
        ST_RUN: begin
          cnt   <= cnt + 1'b1;
          acc   <= acc_nxt;
          shreg <= shreg_nxt;
        end
        default: ;
      endcase
    end
  end

  // Result select; state is left untouched after DONE so outputs hold in IDLE.
  always_comb begin
    case (op_q)
      OP_MULLO: result = acc[WIDTH-1:0];
      OP_MULHI: result = acc[2*WIDTH-1:WIDTH];
      OP_DIVQ:  result = shreg;
      default:  result = acc[2*WIDTH-1:WIDTH];
    endcase
  end

  // The strobe is masked by rst so a reset landing on DONE never writes.
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE) && !rst;
  assign writeEnabled = done;
  assign writeAddr    = addr_q;
  assign divByZero    = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected writes,
// a negedge monitor pops and compares whenever the write strobe fires.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operandA, operandB;
  logic [3:0]  destAddr;
  logic        busy, done, writeEnabled, divByZero;
  logic [15:0] result;
  logic [3:0]  writeAddr;

  mul_div_unit #(.WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB), .destAddr(destAddr),
    .busy(busy), .done(done), .result(result),
    .writeEnabled(writeEnabled), .writeAddr(writeAddr), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  addr;
    logic        dbz;
    int          when;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [15:0] ref_result(input logic [1:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (b == 0) ? 16'hFFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (writeEnabled === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got write addr=%0d data=0x%0h at cycle %0d, required none",
                 writeAddr, result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("writeAddr", writeAddr, e.addr);
        chk("divByZero", divByZero, e.dbz);
        chk("latency_cycle", cyc, e.when);
        chk("done_eq_we", done, 1'b1);
        chk("busy_in_done", busy, 1'b1);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 right after the acceptance edge.
  task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] d, input bit expect_write);
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, required 0", busy, t);
    end
    start    = 1'b1;
    op       = o;
    operandA = a;
    operandB = b;
    destAddr = d;
    @(posedge clk); #1;
    start    = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    if (expect_write)
      q.push_back('{res: ref_result(o, a, b), addr: d, dbz: o[1] && (b == 0), when: cyc + 16});
    // Inputs changing after acceptance must not matter.
    op       = 2'($urandom);
    operandA = 16'($urandom);
    operandB = 16'($urandom);
    destAddr = 4'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d writes outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00;
    operandA = '0; operandB = '0; destAddr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", writeEnabled, 1'b0);
    chk("rst_result", result, 16'h0);
    chk("rst_writeAddr", writeAddr, 4'h0);
    chk("rst_divByZero", divByZero, 1'b0);

    // Directed cases.
    issue(2'b00, 16'h1234, 16'h0010, 4'd3, 1); drain();
    issue(2'b01, 16'hFFFF, 16'hFFFF, 4'd5, 1); drain();
    issue(2'b10, 16'd100,  16'd7,    4'd1, 1); drain();
    issue(2'b11, 16'd100,  16'd7,    4'd2, 1); drain();
    issue(2'b10, 16'h1234, 16'h0000, 4'd6, 1); drain();
    issue(2'b11, 16'h1234, 16'h0000, 4'd7, 1); drain();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_result_idle", result, 16'h1234);
    chk("hold_dbz_idle", divByZero, 1'b1);
    chk("hold_addr_idle", writeAddr, 4'd7);

    // start during a run is ignored.
    issue(2'b10, 16'd50000, 16'd123, 4'd9, 1);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b00; operandA = 16'h00FF; operandB = 16'h0101; destAddr = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    chk("busy_after_ignored_start", busy, 1'b0);

    // Reset 8 cycles into a run aborts with no write.
    issue(2'b00, 16'hBEEF, 16'h1234, 4'd4, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_result_cleared", result, 16'h0);
    repeat (20) @(posedge clk);
    #1;
    issue(2'b01, 16'hBEEF, 16'h1234, 4'd8, 1); drain();

    // Reset coinciding with DONE suppresses the write.
    issue(2'b11, 16'd999, 16'd10, 4'd11, 0);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_in_done_busy", busy, 1'b0);
    issue(2'b11, 16'd999, 16'd10, 4'd12, 1); drain();

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rb;
      case ($urandom_range(0, 5))
        0:       rb = 16'h0000;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      issue(2'($urandom_range(0, 3)), 16'($urandom), rb, 4'($urandom), 1);
    end
    drain();
    repeat (5) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 16-bit unsigned multiply/divide unit for the datapath. It takes its two operands from the register-file read ports and a destination register address. It computes one of four results over 16 cycles and drives the register-file write port (`writeEnabled`, `writeAddr`, result data) for exactly one cycle when finished. Single-cycle ALU operations are unaffected; the control unit stalls on `busy` while a mul/div is in flight.

## Interface
Parameters:
- `WIDTH`, 16: operand/result width; also the iteration count.
- `ADDR_WIDTH`, 4: register address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; accepted only in IDLE.
- `op`  in  2  operation select: 00 MULLO, 01 MULHI, 10 DIVQ, 11 DIVR.
- `operandA`  in  WIDTH  multiplicand / dividend (register-file `output1`).
- `operandB`  in  WIDTH  multiplier / divisor (register-file `output2`).
- `destAddr`  in  ADDR_WIDTH  destination register.
- `busy`  out  1  high from acceptance through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  selected result; feeds register-file `inp`.
- `writeEnabled`  out  1  register-file write strobe; equal to `done`.
- `writeAddr`  out  ADDR_WIDTH  latched `destAddr`.
- `divByZero`  out  1  qualifies `done`; high when a DIVQ/DIVR had `operandB == 0`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`.
  - Latch `operandA`, `operandB`, `op` and `destAddr`.
  - Clear the 2·WIDTH accumulator and set the step counter to 0.
  - Input changes after acceptance have no effect.
- RUN: one step per cycle; counter increments. After step WIDTH-1, go to DONE.
  - MUL (shift-add): if multiplier LSB is 1, add the multiplicand into the upper half of the accumulator. Then shift the {carry, accumulator} pair right by 1 and shift the multiplier right by 1. The result is the 32-bit product.
  - DIV (restoring): shift the {remainder, dividend} pair left by 1. If remainder ≥ divisor, subtract the divisor and set the quotient LSB. A 17-bit compare/subtract is used, so no overflow is lost.
- DONE: one cycle.
  - `done = writeEnabled = 1`.
  - `result` is selected by `op`: MULLO = product[15:0], MULHI = product[31:16], DIVQ = quotient, DIVR = remainder.
  - Next state is IDLE unconditionally.
- Divide by zero:
  - The iteration runs normally and naturally yields quotient 0xFFFF and remainder equal to the dividend; these values are required.
  - `divByZero = 1` during DONE, and the write still occurs.
  - MUL ops never set `divByZero`.
- `start` while `busy` is ignored, with no queuing.
- `result`, `writeAddr` and `divByZero` hold their last values in IDLE. `writeEnabled` is 0 outside DONE.
- All arithmetic is unsigned and no exceptions are raised.

## Timing
- Acceptance edge E0 (IDLE with `start = 1`). `busy` is high after E0.
- DONE occupies the cycle after edge E0+WIDTH, i.e. `done` is visible 16 cycles after acceptance. Edge E0+WIDTH+1 writes the register file and returns to IDLE, and `busy` falls then.
- Back-to-back operation: earliest next acceptance is the edge at E0+WIDTH+1, giving a throughput of one operation per 17 cycles.
- Reset: state IDLE, counter 0, and all outputs 0 (`busy`, `done`, `writeEnabled`, `result`, `writeAddr`, `divByZero`).
- `rst` during RUN or DONE aborts the operation. No write is issued, including when `rst` coincides with DONE, since the strobe is suppressed from the same edge.
- `rst` and `start` in the same cycle: `rst` wins and the request is dropped.

## Structure
- Package `mdu_pkg`:
  - `op` encodings (OP_MULLO, OP_MULHI, OP_DIVQ, OP_DIVR).
  - State enum (ST_IDLE, ST_RUN, ST_DONE).
  - Default width constants.
- Sub-module: none. FSM, counter and the shared accumulator/adder live in one module. The adder is reused as the subtractor for division.

## Test plan
- MULLO 0x1234 × 0x0010, destAddr 3 → `done` 16 cycles after acceptance; `result` 0x2340, `writeAddr` 3, one-cycle `writeEnabled`.
- MULHI 0xFFFF × 0xFFFF → `result` 0xFFFE (product 0xFFFE0001); `divByZero` 0.
- DIVQ 100 / 7 → 0x000E; separate DIVR 100 / 7 → 0x0002.
- DIVQ 0x1234 / 0 → `result` 0xFFFF, `divByZero` 1. DIVR 0x1234 / 0 → `result` 0x1234, `divByZero` 1. Write occurs in both cases.
- Pulse `start` with different operands at cycle 5 of a run → ignored; the original result and address are written and no second `done` follows.
- Assert `rst` 8 cycles after acceptance → `busy` 0 on the next cycle, no `writeEnabled` pulse; a fresh `start` afterwards completes normally.
